// File: rtl/wide_add_seq_pkg.sv
// Shared types and sizing helpers for the slice-serial wide adder.
// The subtract option (WIDE_ADD_SEQ_SUB_EN) lives in the top, not here.
package wide_add_seq_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int num_slices(input int width);
      return width / SLICE_W;
   endfunction

   // Slice index must be at least one bit wide even when only one slice exists.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wide_add_seq_adder.sv
// The team's 4-bit ripple-carry Adder; purely combinational.
// Its clock and reset ports exist only for interface compatibility.
module Adder
   import wide_add_seq_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic [SLICE_W-1:0] io_A,
   input  logic [SLICE_W-1:0] io_B,
   input  logic               io_Cin,
   output logic [SLICE_W-1:0] io_Sum,
   output logic               io_Cout
);

   logic [SLICE_W:0] carry;
   logic             unused_clk_rst;

   assign unused_clk_rst = clock ^ reset;
   assign carry[0]       = io_Cin;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      assign io_Sum[i]   = io_A[i] ^ io_B[i] ^ carry[i];
      assign carry[i+1]  = (io_A[i] & io_B[i]) | (carry[i] & (io_A[i] ^ io_B[i]));
   end

   assign io_Cout = carry[SLICE_W];

endmodule

// File: rtl/wide_add_seq.sv
// Slice-serial WIDTH-bit adder: streams 4-bit slices LSB first through one Adder.
// Define WIDE_ADD_SEQ_SUB_EN to add the io_in_sub port (A - B via ~B + 1).
//
// state | meaning
// IDLE  | waiting for an operand bundle, io_in_ready high
// RUN   | one slice per cycle through the adder, carry registered between slices
// DONE  | result held on io_out_* until the consumer takes it
module wide_add_seq
   import wide_add_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_in_a,
   input  logic [WIDTH-1:0] io_in_b,
   input  logic             io_in_cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
   input  logic             io_in_sub,
`endif
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out_sum,
   output logic             io_out_cout,
   output logic             io_out_ovf
);

   localparam int                N        = num_slices(WIDTH);
   localparam int                IDX_W    = idx_width(N);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

   if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_chk
      $error("wide_add_seq: WIDTH must be a positive multiple of 4");
   end

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [WIDTH-1:0]   b_eff;
   logic               cin_eff;
   logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
   logic               co_sl;

`ifdef WIDE_ADD_SEQ_SUB_EN
   assign b_eff   = io_in_sub ? ~io_in_b : io_in_b;
   assign cin_eff = io_in_sub | io_in_cin;
`else
   assign b_eff   = io_in_b;
   assign cin_eff = io_in_cin;
`endif

   assign a_sl = a_q[idx_q*SLICE_W +: SLICE_W];
   assign b_sl = b_q[idx_q*SLICE_W +: SLICE_W];

   Adder u_adder (
      .clock   (clock),
      .reset   (reset),
      .io_A    (a_sl),
      .io_B    (b_sl),
      .io_Cin  (carry_q),
      .io_Sum  (s_sl),
      .io_Cout (co_sl)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (io_in_valid) begin
               a_d     = io_in_a;
               b_d     = b_eff;
               carry_d = cin_eff;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q*SLICE_W +: SLICE_W] = s_sl;
            carry_d = co_sl;
            if (idx_q == LAST_IDX) begin
               cout_d  = co_sl;
               // s_sl[MSB] is the final result sign bit on the last slice
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_sl[SLICE_W-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (io_out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign io_in_ready  = (state_q == IDLE);
   assign io_out_valid = (state_q == DONE);
   assign io_out_sum   = sum_q;
   assign io_out_cout  = cout_q;
   assign io_out_ovf   = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq at WIDTH=16 and WIDTH=4 (single slice).
// Subtract cases are exercised when WIDE_ADD_SEQ_SUB_EN is defined.
module tb_wide_add_seq;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        in_valid = 1'b0, in_ready;
   logic [15:0] a = '0, b = '0;
   logic        cin = 1'b0;
   logic        out_valid, out_ready = 1'b1;
   logic [15:0] sum;
   logic        cout, ovf;

   logic        in_valid4 = 1'b0, in_ready4;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        cin4 = 1'b0;
   logic        out_valid4;
   logic [3:0]  sum4;
   logic        cout4, ovf4;
`ifdef WIDE_ADD_SEQ_SUB_EN
   logic        sub = 1'b0, sub4 = 1'b0;
`endif

   exp_t q16[$];
   exp_t q4[$];
   int   tests = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   acc16 = 0, acc4 = 0;
   bit   rand_bp = 1'b0;
   logic fixed_ready = 1'b1;

   always #5 clock = ~clock;

   wide_add_seq #(.WIDTH(16)) dut (
      .clock(clock), .reset(reset),
      .io_in_valid(in_valid), .io_in_ready(in_ready),
      .io_in_a(a), .io_in_b(b), .io_in_cin(cin),
`ifdef WIDE_ADD_SEQ_SUB_EN
      .io_in_sub(sub),
`endif
      .io_out_valid(out_valid), .io_out_ready(out_ready),
      .io_out_sum(sum), .io_out_cout(cout), .io_out_ovf(ovf)
   );

   wide_add_seq #(.WIDTH(4)) dut4 (
      .clock(clock), .reset(reset),
      .io_in_valid(in_valid4), .io_in_ready(in_ready4),
      .io_in_a(a4), .io_in_b(b4), .io_in_cin(cin4),
`ifdef WIDE_ADD_SEQ_SUB_EN
      .io_in_sub(sub4),
`endif
      .io_out_valid(out_valid4), .io_out_ready(out_ready),
      .io_out_sum(sum4), .io_out_cout(cout4), .io_out_ovf(ovf4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: true integer sum for the carry, true signed sum for overflow.
   function automatic exp_t model(input int w, input logic [15:0] ta, input logic [15:0] tb_,
                                  input logic tcin, input logic tsub);
      longint m, be, ci, tot, ia, ib, is;
      exp_t   e;
      m   = longint'(1) << w;
      be  = tsub ? (m - 1 - longint'(tb_)) : longint'(tb_);
      ci  = (tsub || tcin) ? 1 : 0;
      if (!tsub) ci = tcin ? 1 : 0;
      tot = longint'(ta) + be + ci;
      e.sum  = 16'(tot % m);
      e.cout = (tot >= m);
      ia  = (longint'(ta) >= m / 2) ? longint'(ta) - m : longint'(ta);
      ib  = (be >= m / 2) ? be - m : be;
      is  = ia + ib + ci;
      e.ovf = (is < -(m / 2)) || (is >= m / 2);
      return e;
   endfunction

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   initial forever begin
      @(posedge clock);
      #1;
      out_ready = rand_bp ? 1'($urandom_range(0, 1)) : fixed_ready;
   end

   task automatic send(input bit wide, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tcin, input logic tsub);
      int   n;
      bit   ok;
      logic s_eff;
`ifdef WIDE_ADD_SEQ_SUB_EN
      s_eff = tsub;
      if (wide) sub = tsub; else sub4 = tsub;
`else
      s_eff = 1'b0;
`endif
      if (wide) begin
         in_valid = 1'b1; a = ta; b = tb_; cin = tcin;
      end else begin
         in_valid4 = 1'b1; a4 = ta[3:0]; b4 = tb_[3:0]; cin4 = tcin;
      end
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 200) begin
         @(negedge clock);
         ok = wide ? in_ready : in_ready4;
         @(posedge clock);
         #1;
         n++;
      end
      if (!ok) check(wide ? "accept16_timeout" : "accept4_timeout", 0, 1);
      else if (wide) begin
         q16.push_back(model(16, ta, tb_, tcin, s_eff));
         acc16 = cyc;
      end else begin
         q4.push_back(model(4, {12'h0, ta[3:0]}, {12'h0, tb_[3:0]}, tcin, s_eff));
         acc4 = cyc;
      end
      // Scramble inputs while busy; they must be ignored.
      if (wide) begin
         in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      end else begin
         in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      end
   endtask

   logic        pv16 = 1'b0, ps16 = 1'b0;
   logic [17:0] hold16;
   exp_t        e16;
   always @(negedge clock) begin
      if (ps16) begin
         check("hold16_valid", out_valid, 1);
         check("hold16_out", {sum, cout, ovf}, hold16);
      end
      if (out_valid && !pv16) check("latency16", cyc - acc16, 4);
      if (out_valid && out_ready) begin
         if (q16.size() == 0) check("unexpected16", 1, 0);
         else begin
            e16 = q16.pop_front();
            check("sum16", sum, e16.sum);
            check("cout16", cout, e16.cout);
            check("ovf16", ovf, e16.ovf);
         end
      end
      pv16   = out_valid;
      ps16   = out_valid && !out_ready;
      hold16 = {sum, cout, ovf};
   end

   logic        pv4 = 1'b0, ps4 = 1'b0;
   logic [5:0]  hold4;
   exp_t        e4;
   always @(negedge clock) begin
      if (ps4) check("hold4_out", {out_valid4, sum4, cout4, ovf4}, {1'b1, hold4});
      if (out_valid4 && !pv4) check("latency4", cyc - acc4, 1);
      if (out_valid4 && out_ready) begin
         if (q4.size() == 0) check("unexpected4", 1, 0);
         else begin
            e4 = q4.pop_front();
            check("sum4", sum4, e4.sum[3:0]);
            check("cout4", cout4, e4.cout);
            check("ovf4", ovf4, e4.ovf);
         end
      end
      pv4   = out_valid4;
      ps4   = out_valid4 && !out_ready;
      hold4 = {sum4, cout4, ovf4};
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clock);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", {sum, cout, ovf}, 18'h0);
      check("rst4_out", {in_ready4, out_valid4, sum4, cout4, ovf4}, {1'b1, 1'b0, 6'h0});
      reset = 1'b0;
      @(posedge clock);
      #1;

      send(1, 16'h00FF, 16'h0001, 0, 0);
      send(1, 16'hFFFF, 16'h0001, 0, 0);
      send(1, 16'h7FFF, 16'h0001, 0, 0);
      send(1, 16'h8000, 16'hFFFF, 1, 0);
`ifdef WIDE_ADD_SEQ_SUB_EN
      send(1, 16'h0005, 16'h0007, 0, 1);
      send(1, 16'h8000, 16'h0001, 1, 1);
      send(0, 16'h0003, 16'h0005, 0, 1);
`endif
      send(0, 16'h000F, 16'h0001, 1, 0);
      send(0, 16'h0007, 16'h0001, 0, 0);

      // Backpressure: hold a finished result for ten cycles.
      n = 0;
      while ((!in_ready || q16.size() != 0) && n < 100) begin
         @(negedge clock);
         n++;
      end
      fixed_ready = 1'b0;
      @(posedge clock);
      #1;
      send(1, 16'h1234, 16'h1111, 0, 0);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("bp_valid_seen", out_valid, 1);
      repeat (10) begin
         @(negedge clock);
         check("bp_sum", sum, 16'h2345);
         check("bp_flags", {cout, ovf, out_valid, in_ready}, 4'b0010);
      end
      fixed_ready = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;
      check("bp_release", {in_ready, out_valid}, 2'b10);

      // Reset in the second RUN cycle, after slice 0 produced a carry.
      send(1, 16'h000F, 16'h0001, 0, 0);
      void'(q16.pop_back());
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("midrst_ready_valid", {in_ready, out_valid}, 2'b10);
      check("midrst_out", {sum, cout, ovf}, 18'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      send(1, 16'h0001, 16'h0001, 0, 0);

      rand_bp = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         if (i % 2 == 0) send(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      rand_bp = 1'b0;
      fixed_ready = 1'b1;

      n = 0;
      while ((q16.size() != 0 || q4.size() != 0) && n < 500) begin
         @(negedge clock);
         n++;
      end
      check("drain16", q16.size(), 0);
      check("drain4", q4.size(), 0);
      repeat (2) @(posedge clock);

      $display("test done: total=%0d bad=%0d", tests, bad);
      $finish;
   end

endmodule
